sub_serial: RTL and testbench

SUB_SERIAL -- requirements
Module: sub_serial

---
 rtl/sub_serial.sv | 99 +++++++++
 tb/tb_sub_serial.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/sub_serial.sv
// Bit-serial unsigned subtractor, LSB first, one bit per clock.
// Valid/ready handshake on both the operand and the result side.
module sub_serial #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             result_valid,
    input  logic             result_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             zero
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] FULL = CW'(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t          state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] diff_q;
    logic             br_q;
    logic [CW-1:0]    cnt_q;

    logic ai;
    logic bi;
    logic d_d;
    logic br_d;

    assign ai   = a_q[0];
    assign bi   = b_q[0];
    assign d_d  = ai ^ bi ^ br_q;
    assign br_d = (~ai & bi) | (~(ai ^ bi) & br_q);

    // Handshake flags come straight from the state register.
    assign start_ready  = (state_q == IDLE);
    assign result_valid = (state_q == DONE);

    // zero is qualified by a full count so it reads 0 after reset
    // and after an accept, yet holds its result value in IDLE.
    assign diff       = diff_q;
    assign borrow_out = br_q;
    assign zero       = (cnt_q == FULL) & ~|diff_q;

    // Control FSM and serial datapath: capture, shift, hand off.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            diff_q  <= '0;
            br_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_valid) begin
                        a_q     <= a;
                        b_q     <= b;
                        diff_q  <= '0;
                        br_q    <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= BUSY;
                    end
                end
                BUSY: begin
                    diff_q <= {d_d, diff_q[WIDTH-1:1]};
                    a_q    <= {1'b0, a_q[WIDTH-1:1]};
                    b_q    <= {1'b0, b_q[WIDTH-1:1]};
                    br_q   <= br_d;
                    cnt_q  <= cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    if (result_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sub_serial.sv
// Self-checking bench for sub_serial at WIDTH=4 and WIDTH=8.
// Expected results are queued at accept and popped at the handshake.
module tb_sub_serial;

    logic clk;
    logic rst_n;

    logic       sv4, sr4, rv4, rr4, bo4, z4;
    logic [3:0] a4, b4, d4;
    logic       sv8, sr8, rv8, rr8, bo8, z8;
    logic [7:0] a8, b8, d8;

    typedef struct {
        logic [15:0] d;
        logic        bo;
        logic        z;
    } exp_t;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] d;
        logic       bo;
        logic       z;
    } vec_t;

    exp_t sb[$];
    vec_t vt[4];
    int   n_cmp;
    int   n_err;

    sub_serial #(.WIDTH(4)) u4 (
        .clk(clk), .rst_n(rst_n),
        .start_valid(sv4), .start_ready(sr4),
        .a(a4), .b(b4),
        .result_valid(rv4), .result_ready(rr4),
        .diff(d4), .borrow_out(bo4), .zero(z4)
    );

    sub_serial #(.WIDTH(8)) u8 (
        .clk(clk), .rst_n(rst_n),
        .start_valid(sv8), .start_ready(sr8),
        .a(a8), .b(b8),
        .result_valid(rv8), .result_ready(rr8),
        .diff(d8), .borrow_out(bo8), .zero(z8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    task automatic drive(input int w, input logic sv,
                         input logic [15:0] av, input logic [15:0] bv,
                         input logic rr);
        if (w == 4) begin
            sv4 = sv; a4 = av[3:0]; b4 = bv[3:0]; rr4 = rr;
        end else begin
            sv8 = sv; a8 = av[7:0]; b8 = bv[7:0]; rr8 = rr;
        end
    endtask

    function automatic logic rd_sr(input int w);
        return (w == 4) ? sr4 : sr8;
    endfunction

    function automatic logic rd_rv(input int w);
        return (w == 4) ? rv4 : rv8;
    endfunction

    function automatic logic [15:0] rd_d(input int w);
        return (w == 4) ? {12'd0, d4} : {8'd0, d8};
    endfunction

    function automatic logic rd_bo(input int w);
        return (w == 4) ? bo4 : bo8;
    endfunction

    function automatic logic rd_z(input int w);
        return (w == 4) ? z4 : z8;
    endfunction

    function automatic exp_t model(input int w, input logic [15:0] av,
                                   input logic [15:0] bv);
        exp_t e;
        logic [15:0] m;
        m    = 16'((32'd1 << w) - 1);
        e.d  = (av - bv) & m;
        e.bo = (av & m) < (bv & m);
        e.z  = (e.d == 16'd0);
        return e;
    endfunction

    // One operation. Latency is counted in edges inclusive of the
    // accept edge; result must appear after exactly w+1 of them.
    task automatic op(input int w, input logic [15:0] av,
                      input logic [15:0] bv, input exp_t e,
                      input int hold, input logic rr_early);
        exp_t        got;
        int          n;
        logic [15:0] d0;
        logic        b0;
        logic        z0;
        @(negedge clk);
        chk("start_ready_pre", 32'(rd_sr(w)), 32'd1);
        drive(w, 1'b1, av, bv, rr_early);
        sb.push_back(e);
        @(negedge clk);
        n = 1;
        drive(w, 1'b0, 16'($urandom), 16'($urandom), rr_early);
        while (!rd_rv(w) && n < 40) begin
            chk("rv_early", 32'(rd_rv(w)), 32'd0);
            @(negedge clk);
            n++;
        end
        chk("latency", 32'(n), 32'(w + 1));
        d0 = rd_d(w);
        b0 = rd_bo(w);
        z0 = rd_z(w);
        for (int i = 0; i < hold; i++) begin
            drive(w, 1'b1, 16'($urandom), 16'($urandom), 1'b0);
            @(negedge clk);
            chk("hold_rv", 32'(rd_rv(w)), 32'd1);
            chk("hold_sr", 32'(rd_sr(w)), 32'd0);
            chk("hold_diff", 32'(rd_d(w)), 32'(d0));
            chk("hold_bo", 32'(rd_bo(w)), 32'(b0));
            chk("hold_z", 32'(rd_z(w)), 32'(z0));
        end
        got = sb.pop_front();
        chk("diff", 32'(rd_d(w)), 32'(got.d));
        chk("borrow", 32'(rd_bo(w)), 32'(got.bo));
        chk("zero", 32'(rd_z(w)), 32'(got.z));
        drive(w, 1'b0, av, bv, 1'b1);
        @(negedge clk);
        chk("idle_sr", 32'(rd_sr(w)), 32'd1);
        chk("idle_rv", 32'(rd_rv(w)), 32'd0);
        drive(w, 1'b0, av, bv, 1'b0);
    endtask

    initial begin
        exp_t e;
        logic [15:0] ra;
        logic [15:0] rb;
        n_cmp = 0;
        n_err = 0;
        drive(4, 1'b0, 16'd0, 16'd0, 1'b0);
        drive(8, 1'b0, 16'd0, 16'd0, 1'b0);
        vt[0] = '{a: 4'd5, b: 4'd3, d: 4'h2, bo: 1'b0, z: 1'b0};
        vt[1] = '{a: 4'd3, b: 4'd5, d: 4'hE, bo: 1'b1, z: 1'b0};
        vt[2] = '{a: 4'd7, b: 4'd7, d: 4'h0, bo: 1'b0, z: 1'b1};
        vt[3] = '{a: 4'd0, b: 4'd1, d: 4'hF, bo: 1'b1, z: 1'b0};

        rst_n = 1'b0;
        #1;
        chk("rst_sr", 32'(sr4), 32'd1);
        chk("rst_rv", 32'(rv4), 32'd0);
        chk("rst_diff", 32'(d4), 32'd0);
        chk("rst_bo", 32'(bo4), 32'd0);
        chk("rst_z", 32'(z4), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 4; i++) begin
            e.d  = {12'd0, vt[i].d};
            e.bo = vt[i].bo;
            e.z  = vt[i].z;
            op(4, {12'd0, vt[i].a}, {12'd0, vt[i].b}, e, 0, 1'b1);
        end

        op(4, 16'd6, 16'd2, model(4, 16'd6, 16'd2), 10, 1'b0);

        // Reset two edges into BUSY discards the operation.
        @(negedge clk);
        drive(4, 1'b1, 16'd2, 16'd1, 1'b1);
        @(negedge clk);
        drive(4, 1'b0, 16'd0, 16'd0, 1'b1);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_sr", 32'(sr4), 32'd1);
        chk("mid_rst_rv", 32'(rv4), 32'd0);
        chk("mid_rst_diff", 32'(d4), 32'd0);
        chk("mid_rst_bo", 32'(bo4), 32'd0);
        repeat (2) @(negedge clk);
        chk("in_rst_rv", 32'(rv4), 32'd0);
        rst_n = 1'b1;
        drive(4, 1'b0, 16'd0, 16'd0, 1'b0);
        e.d  = 16'd5;
        e.bo = 1'b0;
        e.z  = 1'b0;
        op(4, 16'd9, 16'd4, e, 0, 1'b1);

        for (int x = 0; x < 16; x++) begin
            for (int y = 0; y < 16; y++) begin
                op(4, 16'(x), 16'(y), model(4, 16'(x), 16'(y)), 0, 1'b1);
            end
        end

        for (int i = 0; i < 200; i++) begin
            ra = 16'($urandom_range(0, 255));
            rb = 16'($urandom_range(0, 255));
            op(8, ra, rb, model(8, ra, rb), (i % 7 == 0) ? 2 : 0,
               (i % 7 == 0) ? 1'b0 : 1'b1);
        end
        op(8, 16'd0, 16'd255, model(8, 16'd0, 16'd255), 0, 1'b1);
        op(8, 16'd200, 16'd200, model(8, 16'd200, 16'd200), 0, 1'b1);

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
